// File: rtl/tracking.sv
// tracking: colour-blob tracker behind a dual-clock input FIFO (clock_25 -> clock_50).
// Build option TRACKING_MASK_EN turns out_dout into a green/not-green mask instead of a passthrough.
module tracking #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int G_MIN      = 128,
    parameter int RB_MAX     = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        clock_25,
    input  logic        in_wr_en,
    input  logic [23:0] in_din,
    output logic        in_full,
    output logic [23:0] out_dout,
    output logic        valid,
    output logic [11:0] center_x,
    output logic [11:0] center_y,
    output logic [11:0] width,
    output logic [11:0] height
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [11:0] X_LAST   = 12'(WIDTH - 1);
    localparam logic [11:0] Y_LAST   = 12'(HEIGHT - 1);
    localparam logic [7:0]  G_MIN_V  = 8'(G_MIN);
    localparam logic [7:0]  RB_MAX_V = 8'(RB_MAX);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [23:0] mem_r [FIFO_DEPTH];
    logic [AW:0] wbin_r, wgray_r, rq1_r, rq2_r, wbin_next_s, wgray_next_s;
    logic [AW:0] rbin_r, rgray_r, wq1_r, wq2_r, rbin_next_s;
    logic        push_s, full_r, pop_s;

    assign push_s       = in_wr_en & ~full_r;
    assign wbin_next_s  = wbin_r + {{AW{1'b0}}, push_s};
    assign wgray_next_s = bin2gray(wbin_next_s);

    // write pointer, registered full flag and read-pointer synchroniser
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            wbin_r  <= '0;
            wgray_r <= '0;
            rq1_r   <= '0;
            rq2_r   <= '0;
            full_r  <= 1'b0;
        end else begin
            wbin_r  <= wbin_next_s;
            wgray_r <= wgray_next_s;
            rq1_r   <= rgray_r;
            rq2_r   <= rq1_r;
            full_r  <= (wgray_next_s == {~rq2_r[AW:AW-1], rq2_r[AW-2:0]});
        end
    end

    // FIFO storage, written from the pixel clock
    always_ff @(posedge clock_25) begin
        if (push_s) begin
            mem_r[wbin_r[AW-1:0]] <= in_din;
        end
    end

    // empty is the Gray pointers matching, so pop whenever they differ
    assign pop_s       = (rgray_r != wq2_r);
    assign rbin_next_s = rbin_r + {{AW{1'b0}}, pop_s};

    // read pointer and write-pointer synchroniser
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            rbin_r  <= '0;
            rgray_r <= '0;
            wq1_r   <= '0;
            wq2_r   <= '0;
        end else begin
            rbin_r  <= rbin_next_s;
            rgray_r <= bin2gray(rbin_next_s);
            wq1_r   <= wgray_r;
            wq2_r   <= wq1_r;
        end
    end

    logic [23:0] pix_s, dout_s;
    logic        green_s, frame_end_s;
    logic [11:0] x_r, y_r;
    logic        found_r, nfound_s;
    logic [11:0] min_x_r, max_x_r, min_y_r, max_y_r;
    logic [11:0] nmin_x_s, nmax_x_s, nmin_y_s, nmax_y_s;

    assign pix_s       = mem_r[rbin_r[AW-1:0]];
    assign green_s     = (pix_s[15:8] >= G_MIN_V) && (pix_s[7:0] < RB_MAX_V) && (pix_s[23:16] < RB_MAX_V);
    assign frame_end_s = pop_s && (x_r == X_LAST) && (y_r == Y_LAST);

`ifdef TRACKING_MASK_EN
    assign dout_s = green_s ? 24'hFFFFFF : 24'h000000;
`else
    assign dout_s = pix_s;
`endif

    // box including the pixel being popped
    always_comb begin
        nfound_s = found_r;
        nmin_x_s = min_x_r;
        nmax_x_s = max_x_r;
        nmin_y_s = min_y_r;
        nmax_y_s = max_y_r;
        if (pop_s && green_s) begin
            nfound_s = 1'b1;
            nmin_x_s = (!found_r || (x_r < min_x_r)) ? x_r : min_x_r;
            nmax_x_s = (!found_r || (x_r > max_x_r)) ? x_r : max_x_r;
            nmin_y_s = (!found_r || (y_r < min_y_r)) ? y_r : min_y_r;
            nmax_y_s = (!found_r || (y_r > max_y_r)) ? y_r : max_y_r;
        end else begin
            nfound_s = found_r;
        end
    end

    logic        snap_found_r, fe_pend_r, hold_r, valid_r;
    logic [11:0] snap_min_x_r, snap_max_x_r, snap_min_y_r, snap_max_y_r;
    logic [12:0] sum_x_s, sum_y_s;
    logic [11:0] res_cx_s, res_cy_s, res_w_s, res_h_s;
    logic [11:0] cx_r, cy_r, w_r, h_r;
    logic [23:0] dout_r;

    // raster position, running box, frame-end snapshot and pixel output
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            x_r          <= 12'd0;
            y_r          <= 12'd0;
            found_r      <= 1'b0;
            min_x_r      <= 12'd0;
            max_x_r      <= 12'd0;
            min_y_r      <= 12'd0;
            max_y_r      <= 12'd0;
            fe_pend_r    <= 1'b0;
            snap_found_r <= 1'b0;
            snap_min_x_r <= 12'd0;
            snap_max_x_r <= 12'd0;
            snap_min_y_r <= 12'd0;
            snap_max_y_r <= 12'd0;
            dout_r       <= 24'h000000;
        end else begin
            if (pop_s) begin
                dout_r <= dout_s;
                if (x_r == X_LAST) begin
                    x_r <= 12'd0;
                    y_r <= (y_r == Y_LAST) ? 12'd0 : y_r + 12'd1;
                end else begin
                    x_r <= x_r + 12'd1;
                end
            end
            fe_pend_r <= frame_end_s;
            if (frame_end_s) begin
                snap_found_r <= nfound_s;
                snap_min_x_r <= nmin_x_s;
                snap_max_x_r <= nmax_x_s;
                snap_min_y_r <= nmin_y_s;
                snap_max_y_r <= nmax_y_s;
                found_r      <= 1'b0;
                min_x_r      <= 12'd0;
                max_x_r      <= 12'd0;
                min_y_r      <= 12'd0;
                max_y_r      <= 12'd0;
            end else begin
                found_r <= nfound_s;
                min_x_r <= nmin_x_s;
                max_x_r <= nmax_x_s;
                min_y_r <= nmin_y_s;
                max_y_r <= nmax_y_s;
            end
        end
    end

    assign sum_x_s = {1'b0, snap_min_x_r} + {1'b0, snap_max_x_r};
    assign sum_y_s = {1'b0, snap_min_y_r} + {1'b0, snap_max_y_r};

    // frame result from the snapshot; an empty frame reports all zeros
    always_comb begin
        res_cx_s = 12'd0;
        res_cy_s = 12'd0;
        res_w_s  = 12'd0;
        res_h_s  = 12'd0;
        if (snap_found_r) begin
            res_cx_s = sum_x_s[12:1];
            res_cy_s = sum_y_s[12:1];
            res_w_s  = snap_max_x_r - snap_min_x_r + 12'd1;
            res_h_s  = snap_max_y_r - snap_min_y_r + 12'd1;
        end else begin
            res_cx_s = 12'd0;
            res_cy_s = 12'd0;
            res_w_s  = 12'd0;
            res_h_s  = 12'd0;
        end
    end

    // result registers and the two-cycle valid pulse (a new result restarts it)
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            cx_r    <= 12'd0;
            cy_r    <= 12'd0;
            w_r     <= 12'd0;
            h_r     <= 12'd0;
            valid_r <= 1'b0;
            hold_r  <= 1'b0;
        end else if (fe_pend_r) begin
            cx_r    <= res_cx_s;
            cy_r    <= res_cy_s;
            w_r     <= res_w_s;
            h_r     <= res_h_s;
            valid_r <= 1'b1;
            hold_r  <= 1'b1;
        end else if (hold_r) begin
            valid_r <= 1'b1;
            hold_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign in_full  = full_r;
    assign out_dout = dout_r;
    assign valid    = valid_r;
    assign center_x = cx_r;
    assign center_y = cy_r;
    assign width    = w_r;
    assign height   = h_r;
endmodule

// File: tb/tb_tracking.sv
// tb_tracking: directed frames on a reduced 40x20 raster with hand-computed box results.
module tb_tracking;
    localparam int W = 40;
    localparam int H = 20;

    logic        clock_50  = 1'b0;
    logic        clock_25  = 1'b0;
    logic        reset     = 1'b0;
    logic        in_wr_en  = 1'b0;
    logic [23:0] in_din    = 24'h000000;
    logic        in_full;
    logic [23:0] out_dout;
    logic        valid;
    logic [11:0] center_x, center_y, width, height;
    logic        clk50_en  = 1'b1;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int run_len = 0;
    logic prev_valid = 1'b0;
    logic [11:0] exp_cx = 12'd0, exp_cy = 12'd0, exp_w = 12'd0, exp_h = 12'd0;

    tracking #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock_50(clock_50), .reset(reset), .clock_25(clock_25),
        .in_wr_en(in_wr_en), .in_din(in_din), .in_full(in_full),
        .out_dout(out_dout), .valid(valid),
        .center_x(center_x), .center_y(center_y), .width(width), .height(height)
    );

    always begin
        #10;
        if (clk50_en) clock_50 = ~clock_50;
    end
    always #20 clock_25 = ~clock_25;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // every result pulse: values on its first cycle, length when it drops
    always @(negedge clock_50) begin
        if (valid && !prev_valid) begin
            pulses++;
            run_len = 1;
            check("center_x", center_x, exp_cx);
            check("center_y", center_y, exp_cy);
            check("width", width, exp_w);
            check("height", height, exp_h);
        end else if (valid) begin
            run_len++;
        end else if (prev_valid) begin
            check("valid_len", run_len, 2);
        end
        prev_valid = valid;
    end

    function automatic logic is_green(input logic [23:0] p);
        return (p[15:8] >= 8'h80) && (p[7:0] < 8'h40) && (p[23:16] < 8'h40);
    endfunction

    function automatic logic [23:0] exp_dout(input logic [23:0] p);
`ifdef TRACKING_MASK_EN
        return is_green(p) ? 24'hFFFFFF : 24'h000000;
`else
        return p;
`endif
    endfunction

    function automatic logic [23:0] pix(input int kind, input int x, input int y);
        logic [23:0] p;
        p = 24'h000000;
        case (kind)
            1: if (x >= 20 && x <= 23 && y >= 5 && y <= 8) p = 24'h00FF00;
               else if (y == 0 && x < 10) p = 24'h0000FF;
            3: if ((x == 0 && y == 0) || (x == W-1 && y == H-1)) p = 24'h00FF00;
            4: if (x == 5 && y == 1) p = 24'h3F7F3F;
               else if (x == 6 && y == 1) p = 24'h3F8040;
               else if (x == 7 && y == 1) p = 24'h408040;
               else if (x == W-1 && y == H-1) p = 24'h3F803F;
            5: if (x == 2 && y == 2) p = 24'h00FF00;
               else if (x == 5 && y == 1) p = 24'h3F8040;
               else if (x == W-1 && y == H-1) p = 24'h3F7F3F;
            6: if (x == 30 && y == 3) p = 24'h00FF00;
            7: if ((x == 0 || x == 3) && y == 0) p = 24'h00FF00;
            default: p = 24'h000000;
        endcase
        return p;
    endfunction

    task automatic push(input logic [23:0] d);
        @(negedge clock_25);
        in_wr_en = 1'b1;
        in_din   = d;
        @(posedge clock_25);
        #1;
        in_wr_en = 1'b0;
    endtask

    task automatic send_range(input int kind, input int first, input int count);
        for (int i = first; i < first + count; i++) push(pix(kind, i % W, i / W));
    endtask

    task automatic set_exp(input int cx, input int cy, input int w, input int h);
        exp_cx = 12'(cx); exp_cy = 12'(cy); exp_w = 12'(w); exp_h = 12'(h);
    endtask

    task automatic finish_frame(input int target, input logic [23:0] last_pix);
        int t;
        t = 0;
        while (pulses < target && t < 400) begin
            @(negedge clock_50);
            t++;
        end
        repeat (10) @(negedge clock_50);
        check("pulse_count", pulses, target);
        check("hold_center_x", center_x, exp_cx);
        check("hold_width", width, exp_w);
        check("out_dout_last", out_dout, exp_dout(last_pix));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_cx"}, center_x, 12'd0);
        check({tag, "_cy"}, center_y, 12'd0);
        check({tag, "_w"}, width, 12'd0);
        check({tag, "_h"}, height, 12'd0);
        check({tag, "_dout"}, out_dout, 24'h000000);
        check({tag, "_full"}, in_full, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #55;
        check_zero("rst");
        @(negedge clock_50);
        #5 reset = 1'b1;
        repeat (4) @(negedge clock_25);

        // blob with red lead-in pixels
        set_exp(21, 6, 4, 4);
        send_range(1, 0, W*H);
        finish_frame(1, pix(1, W-1, H-1));

        // three identical frames back to back
        send_range(1, 0, W*H);
        send_range(1, 0, W*H);
        send_range(1, 0, W*H);
        finish_frame(4, pix(1, W-1, H-1));

        // empty frame
        set_exp(0, 0, 0, 0);
        send_range(2, 0, W*H);
        finish_frame(5, pix(2, W-1, H-1));

        // opposite corners span the whole raster
        set_exp(19, 9, 40, 20);
        send_range(3, 0, W*H);
        finish_frame(6, pix(3, W-1, H-1));

        // threshold edges: only G=80,R=B=3F (last pixel) qualifies
        set_exp(39, 19, 1, 1);
        send_range(4, 0, W*H);
        finish_frame(7, pix(4, W-1, H-1));

        set_exp(2, 2, 1, 1);
        send_range(5, 0, W*H);
        finish_frame(8, pix(5, W-1, H-1));

        // fill the FIFO with clock_50 stopped; a green extra write must be dropped
        set_exp(30, 3, 1, 1);
        @(negedge clock_50);
        clk50_en = 1'b0;
        send_range(6, 0, 15);
        check("full_at_15", in_full, 1'b0);
        send_range(6, 15, 1);
        check("full_at_16", in_full, 1'b1);
        push(24'h00FF00);
        check("full_after_drop", in_full, 1'b1);
        clk50_en = 1'b1;
        repeat (10) @(negedge clock_25);
        check("full_drained", in_full, 1'b0);
        send_range(6, 16, W*H - 16);
        finish_frame(9, pix(6, W-1, H-1));

        // reset mid-frame, then a fresh frame must start at (0,0)
        send_range(6, 0, 200);
        repeat (6) @(negedge clock_50);
        reset = 1'b0;
        #3;
        check_zero("midrst");
        @(negedge clock_50);
        #5 reset = 1'b1;
        repeat (4) @(negedge clock_25);
        set_exp(1, 0, 4, 1);
        send_range(7, 0, W*H);
        finish_frame(10, pix(7, W-1, H-1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
